// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter between the
// instruction-fetch and data ports.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    RESP_NONE,
    RESP_IRD,
    RESP_DRD,
    RESP_DWR,
    RESP_DERR
  } resp_t;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_WORD = 2'b10;

  localparam logic [3:0] MBE_NONE = 4'b0000;
  localparam logic [3:0] MBE_ALL  = 4'b1111;

  // Expands a 4-bit byte-enable into a 32-bit lane mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_be_decode.sv
// Translates data-port access size and low address bits into SRAM byte
// enables; misaligned or illegal sizes report legal = 0.
module mem_be_decode
  import mem_arb_pkg::*;
(
  input  logic [1:0] dsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       legal
);

  always_comb begin
    be    = MBE_NONE;
    legal = 1'b1;
    case ({dsize, addr_lo})
      {DSIZE_BYTE, 2'b00}: be = 4'b0001;
      {DSIZE_BYTE, 2'b01}: be = 4'b0010;
      {DSIZE_BYTE, 2'b10}: be = 4'b0100;
      {DSIZE_BYTE, 2'b11}: be = 4'b1000;
      {DSIZE_HALF, 2'b00}: be = 4'b0011;
      {DSIZE_HALF, 2'b10}: be = 4'b1100;
      {DSIZE_WORD, 2'b00}: be = MBE_ALL;
      default:             legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-cycle arbiter sharing one synchronous SRAM between fetch and data
// ports; data has priority, bounded by a fetch starvation counter.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IREQ,
  input  logic [31:0]       IADDR,
  output logic              IGNT,
  output logic              IVALID,
  output logic [31:0]       INSTR,
  input  logic              DREQ,
  input  logic [31:0]       DADDR,
  input  logic              DRW,
  input  logic [1:0]        DSIZE,
  input  logic [31:0]       DWDATA,
  output logic              DGNT,
  output logic              DVALID,
  output logic              DERR,
  output logic [31:0]       DRDATA,
  output logic              MCSN,
  output logic [ADDR_W-1:0] MADDR,
  output logic              MWE,
  output logic [3:0]        MBE,
  output logic [31:0]       MDI,
  input  logic [31:0]       MDO
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  resp_t      resp, resp_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic [3:0] be_q, be_nxt;
  logic [3:0] dbe;
  logic       dlegal;
  logic       force_fetch;
  logic       addr_unused;

  assign addr_unused = ^{IADDR[31:ADDR_W+2], IADDR[1:0], DADDR[31:ADDR_W+2]};

  mem_be_decode u_be_decode (
    .dsize   (DSIZE),
    .addr_lo (DADDR[1:0]),
    .be      (dbe),
    .legal   (dlegal)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      resp       <= RESP_NONE;
      starve_cnt <= 4'd0;
      be_q       <= MBE_NONE;
    end else begin
      resp       <= resp_nxt;
      starve_cnt <= starve_nxt;
      be_q       <= be_nxt;
    end
  end

  // Grant, SRAM command and next response phase all come from this cycle's requests.
  always_comb begin
    force_fetch = (starve_cnt == STARVE_LIM);
    IGNT        = !RESET && IREQ && (!DREQ || force_fetch);
    DGNT        = !RESET && DREQ && !(IREQ && force_fetch);
    MCSN        = 1'b1;
    MWE         = 1'b0;
    MBE         = MBE_NONE;
    MADDR       = '0;
    resp_nxt    = RESP_NONE;
    be_nxt      = MBE_NONE;
    starve_nxt  = starve_cnt;

    if (IGNT) begin
      MCSN     = 1'b0;
      MBE      = MBE_ALL;
      MADDR    = IADDR[ADDR_W+1:2];
      resp_nxt = RESP_IRD;
    end else if (DGNT) begin
      if (dlegal) begin
        MCSN     = 1'b0;
        MWE      = DRW;
        MBE      = dbe;
        MADDR    = DADDR[ADDR_W+1:2];
        be_nxt   = dbe;
        resp_nxt = DRW ? RESP_DWR : RESP_DRD;
      end else begin
        resp_nxt = RESP_DERR;
      end
    end

    if (!IREQ || IGNT) begin
      starve_nxt = 4'd0;
    end else if (DGNT && starve_cnt != STARVE_LIM) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  always_comb begin
    IVALID = (resp == RESP_IRD);
    DVALID = (resp == RESP_DRD) || (resp == RESP_DWR) || (resp == RESP_DERR);
    DERR   = (resp == RESP_DERR);
    INSTR  = IVALID ? MDO : '0;
    DRDATA = (resp == RESP_DRD) ? (MDO & lane_mask(be_q)) : '0;
    MDI    = DWDATA;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: behavioural SRAM, a reference memory
// with request-level arbitration, and a queue of expected responses.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 12;
  localparam int STARVE_MAX = 4;
  localparam int RW         = 67;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              IREQ = 1'b0;
  logic [31:0]       IADDR = '0;
  logic              IGNT;
  logic              IVALID;
  logic [31:0]       INSTR;
  logic              DREQ = 1'b0;
  logic [31:0]       DADDR = '0;
  logic              DRW = 1'b0;
  logic [1:0]        DSIZE = 2'b00;
  logic [31:0]       DWDATA = '0;
  logic              DGNT;
  logic              DVALID;
  logic              DERR;
  logic [31:0]       DRDATA;
  logic              MCSN;
  logic [ADDR_W-1:0] MADDR;
  logic              MWE;
  logic [3:0]        MBE;
  logic [31:0]       MDI;
  logic [31:0]       MDO;

  // clock / reset
  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RESET(RESET),
    .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT), .IVALID(IVALID), .INSTR(INSTR),
    .DREQ(DREQ), .DADDR(DADDR), .DRW(DRW), .DSIZE(DSIZE), .DWDATA(DWDATA),
    .DGNT(DGNT), .DVALID(DVALID), .DERR(DERR), .DRDATA(DRDATA),
    .MCSN(MCSN), .MADDR(MADDR), .MWE(MWE), .MBE(MBE), .MDI(MDI), .MDO(MDO)
  );

  // behavioural single-port SRAM
  logic [31:0] sram [0:4095];
  logic [31:0] mdo_q = '0;
  assign MDO = mdo_q;

  always @(posedge CLK) begin
    if (!MCSN) begin
      if (MWE) begin
        for (int b = 0; b < 4; b++) begin
          if (MBE[b]) sram[MADDR][8*b +: 8] <= MDI[8*b +: 8];
        end
      end else begin
        mdo_q <= sram[MADDR];
      end
    end
  end

  // reference model state and scoreboard
  logic [31:0]   ref_mem [0:4095];
  int            losses = 0;
  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of requests (called at posedge+1), checks the previous
  // response and the current grant/command, and returns the observed grants.
  task automatic step(input logic ireq, input logic [31:0] iaddr,
                      input logic dreq, input logic [31:0] daddr,
                      input logic drw, input logic [1:0] dsize,
                      input logic [31:0] dwdata,
                      output logic ig_o, output logic dg_o);
    logic [RW-1:0] e;
    logic          m_ig, m_dg, legal;
    int            nb, lo, word;
    logic [3:0]    be;
    logic [31:0]   mask;
    IREQ = ireq; IADDR = iaddr; DREQ = dreq; DADDR = daddr;
    DRW = drw; DSIZE = dsize; DWDATA = dwdata;
    @(negedge CLK);
    if (exp_q.size() == 0) begin
      check("rsp_queue", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("ivalid", {31'd0, IVALID}, {31'd0, e[66]});
      check("dvalid", {31'd0, DVALID}, {31'd0, e[65]});
      check("derr",   {31'd0, DERR},   {31'd0, e[64]});
      check("instr",  INSTR,  e[63:32]);
      check("drdata", DRDATA, e[31:0]);
    end

    m_ig = ireq && (!dreq || losses == STARVE_MAX);
    m_dg = dreq && !m_ig;
    check("ignt", {31'd0, IGNT}, {31'd0, m_ig});
    check("dgnt", {31'd0, DGNT}, {31'd0, m_dg});

    lo    = int'(daddr % 4);
    nb    = (dsize == 2'b00) ? 1 : (dsize == 2'b01) ? 2 : 4;
    legal = (dsize != 2'b11) && (lo % nb == 0);
    be    = 4'(((1 << nb) - 1) << lo);
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = be[b] ? 8'hFF : 8'h00;

    if (m_ig) begin
      word = int'((iaddr / 4) % 4096);
      check("mcsn_i", {31'd0, MCSN}, 32'd0);
      check("mwe_i",  {31'd0, MWE},  32'd0);
      check("mbe_i",  {28'd0, MBE},  32'hF);
      check("maddr_i", {20'd0, MADDR}, 32'(word));
      exp_q.push_back({3'b100, ref_mem[word], 32'h0});
    end else if (m_dg && legal) begin
      word = int'((daddr / 4) % 4096);
      check("mcsn_d", {31'd0, MCSN}, 32'd0);
      check("mwe_d",  {31'd0, MWE},  {31'd0, drw});
      check("mbe_d",  {28'd0, MBE},  {28'd0, be});
      check("maddr_d", {20'd0, MADDR}, 32'(word));
      if (drw) begin
        ref_mem[word] = (ref_mem[word] & ~mask) | (dwdata & mask);
        exp_q.push_back({3'b010, 32'h0, 32'h0});
      end else begin
        exp_q.push_back({3'b010, 32'h0, ref_mem[word] & mask});
      end
    end else if (m_dg) begin
      check("mcsn_err", {31'd0, MCSN}, 32'd1);
      exp_q.push_back({3'b011, 32'h0, 32'h0});
    end else begin
      check("mcsn_idle", {31'd0, MCSN}, 32'd1);
      check("mwe_idle",  {31'd0, MWE},  32'd0);
      check("mbe_idle",  {28'd0, MBE},  32'd0);
      exp_q.push_back('0);
    end

    if (!ireq || m_ig) losses = 0;
    else if (m_dg) losses++;
    ig_o = IGNT;
    dg_o = DGNT;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(output logic ig_o, output logic dg_o);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, ig_o, dg_o);
  endtask

  logic        ig, dg, ir, dr, rw, p_i, p_d;
  logic [31:0] ia, da, dw;
  logic [1:0]  sz;
  int          fetch_cnt;

  initial begin
    for (int w = 0; w < 4096; w++) begin
      sram[w]    = $urandom;
      ref_mem[w] = sram[w];
    end
    sram[4]    = 32'hE7FE_2001;
    ref_mem[4] = 32'hE7FE_2001;

    // reset state with both requests asserted
    IREQ = 1'b1; DREQ = 1'b1; DADDR = 32'h200; DSIZE = 2'b10;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ignt",   {31'd0, IGNT},   32'd0);
    check("rst_dgnt",   {31'd0, DGNT},   32'd0);
    check("rst_ivalid", {31'd0, IVALID}, 32'd0);
    check("rst_dvalid", {31'd0, DVALID}, 32'd0);
    check("rst_derr",   {31'd0, DERR},   32'd0);
    check("rst_mcsn",   {31'd0, MCSN},   32'd1);
    check("rst_mwe",    {31'd0, MWE},    32'd0);
    check("rst_mbe",    {28'd0, MBE},    32'd0);
    check("rst_instr",  INSTR,  32'd0);
    check("rst_drdata", DRDATA, 32'd0);
    IREQ = 1'b0; DREQ = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b0;
    exp_q.push_back('0);

    // fetch only, three back-to-back grants
    repeat (3) step(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, ig, dg);
    idle(ig, dg);

    // byte write to the top lane, then word read of the same word
    step(1'b0, 32'h0, 1'b1, 32'h203, 1'b1, 2'b00, 32'hAB00_0000, ig, dg);
    step(1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 2'b10, 32'h0, ig, dg);
    check("wr_rd_lane", {24'd0, DRDATA[31:24]}, 32'hAB);

    // misaligned word and illegal size, then confirm memory untouched
    step(1'b0, 32'h0, 1'b1, 32'h102, 1'b1, 2'b10, 32'hDEAD_BEEF, ig, dg);
    step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 2'b11, 32'h1234_5678, ig, dg);
    step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 2'b10, 32'h0, ig, dg);
    idle(ig, dg);

    // simultaneous requests with no starvation history
    step(1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 2'b10, 32'h0, ig, dg);
    check("simul_dgnt", {31'd0, dg}, 32'd1);
    step(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, ig, dg);
    check("simul_ignt", {31'd0, ig}, 32'd1);
    idle(ig, dg);

    // continuous contention: fetch wins every (STARVE_MAX+1)th cycle
    fetch_cnt = 0;
    for (int k = 0; k < 3 * (STARVE_MAX + 1); k++) begin
      step(1'b1, 32'h14, 1'b1, 32'h44, 1'b0, 2'b10, 32'h0, ig, dg);
      check("starve_ignt", {31'd0, ig}, {31'd0, (k % (STARVE_MAX + 1)) == STARVE_MAX});
      if (ig) fetch_cnt++;
    end
    check("starve_count", 32'(fetch_cnt), 32'd3);
    idle(ig, dg);

    // reset asserted while a data read response is pending
    step(1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 2'b10, 32'h0, ig, dg);
    RESET = 1'b1; IREQ = 1'b1; DREQ = 1'b1;
    exp_q.delete();
    losses = 0;
    @(negedge CLK);
    check("rmid_dvalid", {31'd0, DVALID}, 32'd0);
    check("rmid_drdata", DRDATA, 32'd0);
    check("rmid_ignt",   {31'd0, IGNT},   32'd0);
    check("rmid_dgnt",   {31'd0, DGNT},   32'd0);
    check("rmid_mcsn",   {31'd0, MCSN},   32'd1);
    @(posedge CLK);
    #1;
    RESET = 1'b0; IREQ = 1'b0; DREQ = 1'b0;
    exp_q.push_back('0);
    step(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, ig, dg);
    check("post_rst_ignt", {31'd0, ig}, 32'd1);
    idle(ig, dg);

    // randomized traffic; ungranted requests are held stable
    p_i = 1'b0; p_d = 1'b0;
    ir = 1'b0; dr = 1'b0; ia = '0; da = '0; dw = '0; rw = 1'b0; sz = 2'b00;
    for (int n = 0; n < 500; n++) begin
      if (!p_i) begin
        ir = ($urandom_range(0, 9) < 6);
        ia = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
      end
      if (!p_d) begin
        dr = ($urandom_range(0, 9) < 6);
        da = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
        sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        rw = 1'($urandom_range(0, 1));
        dw = $urandom;
      end
      step(ir, ia, dr, da, rw, sz, dw, ig, dg);
      p_i = ir && !ig;
      p_d = dr && !dg;
    end
    idle(ig, dg);
    idle(ig, dg);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
